qpll_drp_master: RTL
====================

# qpll_drp_master

DRP initiator that drives the QPLL common block's DRP slave port (DRPADDR/DRPDI/DRPEN/DRPWE in, DRPDO/DRPRDY out). It accepts read, write and read-modify-write commands from the transceiver reset/reconfig controller. It sequences one DRP transaction at a time, enforces a DRPRDY timeout and returns a single-cycle response. It sits in the DRPCLK domain next to the GTXE2 common wrapper.

## Interface
- TIMEOUT_CYCLES, 64: cycles after DRPEN with no DRPRDY before the access is aborted (range 2..1023).
- DRPCLK  in  1  DRP clock; all logic is on the rising edge.
- DRPRST  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted on edge where VALID&&READY.
- CMD_OP  in  2  00 read, 01 write, 10 RMW, 11 reserved.
- CMD_ADDR  in  8  DRP address.
- CMD_DATA  in  16  write data.
- CMD_MASK  in  16  RMW mask; 1 = bit taken from CMD_DATA, 0 = bit kept from read value.
- RSP_VALID  out  1  one-cycle response strobe; no backpressure.
- RSP_DATA  out  16  read: DRPDO; write: CMD_DATA; RMW: merged value written; 0 on error.
- RSP_ERR  out  1  timeout or reserved op; valid with RSP_VALID.
- DRPADDR  out  8, DRPDI  out  16, DRPEN  out  1, DRPWE  out  1  DRP master outputs.
- DRPDO  in  16, DRPRDY  in  1  DRP slave returns.

## Operation
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP.
- IDLE: CMD_READY=1. On accept, latch OP/ADDR/DATA/MASK.
  - Read or RMW goes to RD_REQ.
  - Write goes to WR_REQ.
  - Reserved op goes to RESP with ERR=1, and no DRP access is made.
- RD_REQ: DRPEN=1, DRPWE=0 for exactly one cycle, then RD_WAIT.
- RD_WAIT: on DRPRDY=1, capture DRPDO.
  - Read goes to RESP.
  - RMW computes merged = (DRPDO & ~MASK) | (DATA & MASK), then goes to WR_REQ.
- WR_REQ: DRPEN=1, DRPWE=1, DRPDI = DATA (write) or merged (RMW) for one cycle, then WR_WAIT.
- WR_WAIT: on DRPRDY=1, go to RESP.
- Timeout: a counter clears in each *_REQ state and increments each cycle in *_WAIT. When it reaches TIMEOUT_CYCLES without DRPRDY, go to RESP with ERR=1 and RSP_DATA=0. An RMW that times out on its read does not issue the write.
- RESP: RSP_VALID=1 for one cycle, then IDLE.
- DRPRDY is ignored in every state other than RD_WAIT/WR_WAIT. This covers stray or late DRPRDY, including one coincident with DRPEN.
- DRPADDR holds the latched address from REQ through WAIT; DRPDI holds its value through WR_WAIT.

## Timing
- Reset values: CMD_READY=0 during reset and 1 in the first cycle after; RSP_VALID=0, RSP_DATA=0, RSP_ERR=0, DRPEN=0, DRPWE=0, DRPADDR=0, DRPDI=0. State is IDLE.
- All outputs are registered.
- Command accepted at edge N: DRPEN is high in cycle N+1.
- DRPRDY sampled high at edge M in a WAIT state: RSP_VALID is high in cycle M+1 (read/write). For RMW, the write DRPEN is high in cycle M+1.
- Minimum latency, slave answering in the cycle after DRPEN:
  - read/write: 3 cycles from accept to RSP_VALID;
  - RMW: 5 cycles.
- Reserved op: RSP_VALID in cycle N+1, RSP_ERR=1.
- Back-to-back: CMD_READY is 0 from the accept edge until the cycle after RSP_VALID, so at most one command is in flight.
- Reset mid-transaction: everything returns to reset values at the next edge. The pending access is abandoned with no response, and a later DRPRDY is ignored.
- Counter width is clog2(TIMEOUT_CYCLES+1). A timeout is flagged on the edge where count == TIMEOUT_CYCLES. DRPRDY arriving on that same edge wins: the access completes normally.

## Structure
- Shared package qpll_drp_pkg: CMD_OP encodings (OP_RD, OP_WR, OP_RMW) and the state enum.
- Sub-module drp_timeout_cnt (clear, enable, TIMEOUT_CYCLES, expired output). It will be reused by the channel DRP master.

## Test plan
- Read of 0x5E; the slave returns DRPRDY 4 cycles after DRPEN with DRPDO=0x21E8 -> exactly one DRPEN with DRPWE=0, DRPADDR=0x5E; RSP_DATA=0x21E8, ERR=0.
- Write 0x0680 to 0x32 -> one DRPEN with DRPWE=1, DRPDI=0x0680; RSP_DATA=0x0680, ERR=0.
- RMW to 0x36 with DATA=0x00A0, MASK=0x00F0; read returns 0x1234 -> write DRPDI=0x12A4, RSP_DATA=0x12A4, two DRPEN pulses in total.
- Slave never asserts DRPRDY, TIMEOUT_CYCLES=64 -> RSP_VALID 65 cycles after DRPEN, ERR=1, RSP_DATA=0, no write phase for RMW. A DRPRDY injected afterwards is ignored.
- CMD_OP=11 -> RSP_ERR=1 in the cycle after accept, DRPEN never asserted.
- DRPRST asserted in RD_WAIT, then DRPRDY pulsed -> no RSP_VALID, all outputs at reset values, CMD_READY=1 in the cycle after reset deasserts.

Source files
------------

// File: rtl/qpll_drp_pkg.sv
// Shared definitions for the QPLL/channel DRP initiators: command opcodes,
// sequencer states and the read-modify-write merge rule.
package qpll_drp_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_RMW = 2'b10,
        OP_RSV = 2'b11
    } drp_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        RESP    = 3'd5
    } drp_state_e;

    // Mask bit 1 takes the new data bit, 0 keeps the bit read from the slave.
    function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] rd_val,
                                                   input logic [DATA_W-1:0] wr_val,
                                                   input logic [DATA_W-1:0] mask);
        return (rd_val & ~mask) | (wr_val & mask);
    endfunction

endpackage

// File: rtl/drp_timeout_cnt.sv
// DRPRDY watchdog shared by the DRP initiators: cleared while a request is
// issued, counts wait cycles and flags expiry on the TIMEOUT_CYCLES-th one.
module drp_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = cnt + 1'b1;
    // Expiry is flagged on the edge that would load TIMEOUT_CYCLES.
    assign expired = en && (cnt_nxt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en && !expired) begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/qpll_drp_master.sv
// Single-outstanding DRP initiator for the QPLL common block: sequences read,
// write and read-modify-write accesses with a DRPRDY timeout.
module qpll_drp_master
    import qpll_drp_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        DRPCLK,
    input  logic        DRPRST,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_OP,
    input  logic [7:0]  CMD_ADDR,
    input  logic [15:0] CMD_DATA,
    input  logic [15:0] CMD_MASK,
    output logic        RSP_VALID,
    output logic [15:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic [7:0]  DRPADDR,
    output logic [15:0] DRPDI,
    output logic        DRPEN,
    output logic        DRPWE,
    input  logic [15:0] DRPDO,
    input  logic        DRPRDY
);

    drp_state_e        state;
    drp_state_e        state_n;
    drp_op_e           op_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] rsp_data_n;
    logic              rsp_err_n;
    logic              accept;
    logic              cnt_clr;
    logic              cnt_en;
    logic              expired;

    assign accept  = (state == IDLE) && CMD_VALID && CMD_READY;
    assign cnt_clr = (state == RD_REQ) || (state == WR_REQ);
    assign cnt_en  = (state == RD_WAIT) || (state == WR_WAIT);

    drp_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (DRPCLK),
        .rst    (DRPRST),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    // DRPRDY is only looked at in the WAIT states; a late or stray strobe
    // anywhere else falls through the default hold.
    always_comb begin
        state_n    = state;
        rsp_data_n = '0;
        rsp_err_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (drp_op_e'(CMD_OP))
                        OP_RD, OP_RMW: state_n = RD_REQ;
                        OP_WR:         state_n = WR_REQ;
                        default: begin
                            state_n   = RESP;
                            rsp_err_n = 1'b1;
                        end
                    endcase
                end
            end
            RD_REQ: state_n = RD_WAIT;
            RD_WAIT: begin
                if (DRPRDY) begin
                    if (op_q == OP_RMW) begin
                        state_n = WR_REQ;
                    end else begin
                        state_n    = RESP;
                        rsp_data_n = DRPDO;
                    end
                end else if (expired) begin
                    state_n   = RESP;
                    rsp_err_n = 1'b1;
                end
            end
            WR_REQ: state_n = WR_WAIT;
            WR_WAIT: begin
                if (DRPRDY) begin
                    state_n    = RESP;
                    rsp_data_n = DRPDI;
                end else if (expired) begin
                    state_n   = RESP;
                    rsp_err_n = 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Every output is decoded from the next state so it is registered.
    always_ff @(posedge DRPCLK) begin
        if (DRPRST) begin
            state     <= IDLE;
            CMD_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= '0;
            RSP_ERR   <= 1'b0;
            DRPEN     <= 1'b0;
            DRPWE     <= 1'b0;
            DRPADDR   <= '0;
            DRPDI     <= '0;
        end else begin
            state     <= state_n;
            CMD_READY <= (state_n == IDLE);
            DRPEN     <= (state_n == RD_REQ) || (state_n == WR_REQ);
            DRPWE     <= (state_n == WR_REQ);
            RSP_VALID <= (state_n == RESP);
            if (state_n == RESP) begin
                RSP_DATA <= rsp_data_n;
                RSP_ERR  <= rsp_err_n;
            end
            if (accept && (CMD_OP != OP_RSV)) begin
                DRPADDR <= CMD_ADDR;
            end
            if (accept && (CMD_OP == OP_WR)) begin
                DRPDI <= CMD_DATA;
            end else if ((state == RD_WAIT) && DRPRDY && (op_q == OP_RMW)) begin
                DRPDI <= rmw_merge(DRPDO, data_q, mask_q);
            end
        end
    end

    always_ff @(posedge DRPCLK) begin
        if (accept) begin
            op_q   <= drp_op_e'(CMD_OP);
            data_q <= CMD_DATA;
            mask_q <= CMD_MASK;
        end
    end

endmodule
